cam_pixel_capture: RTL and testbench
====================================

Name: cam_pixel_capture

Overview:
- Upstream feeder for the ILI9341 driver: samples an OV7670-style 8-bit parallel camera bus (PCLK/VSYNC/HREF/D) in the system clock domain.
- Assembles byte pairs into RGB565 pixels and presents them with a valid/ack handshake that maps onto the driver's dataReady/pixelDataIn.
- Issues a one-cycle frame-start strobe that drives the driver's initPixelStrobe.

Parameters:
- COLS, 240, pixels per line expected
- ROWS, 320, lines per frame expected
- SYNC_STAGES, 2, synchroniser depth on all camera inputs (min 2)

Ports:
- CLK_I  in  1  system clock (50 MHz); camera PCLK must be ≤ CLK_I/4
- RST_I  in  1  reset, asynchronous, active-low
- camPclk  in  1  camera pixel clock, sampled as data
- camVsync  in  1  camera frame sync, active-high
- camHref  in  1  camera line-valid
- camData  in  8  camera byte bus
- pixelAck  in  1  downstream consumed current pixel
- pixelData  out  16  RGB565 pixel, MSB byte received first
- pixelValid  out  1  pixelData holds an unconsumed pixel (to dataReady)
- frameStart  out  1  one-cycle pulse at frame start (to initPixelStrobe)
- frameDone  out  1  one-cycle pulse when ROWS lines captured
- pixelX  out  9  column of pixelData
- pixelY  out  9  row of pixelData
- overflow  out  1  sticky: pixel dropped because slot still full

Behaviour:
- Reset (RST_I low, any time, async): all outputs 0, state IDLE, byte phase 0, counters 0, synchronisers cleared.
- camPclk, camVsync, camHref and camData all pass through SYNC_STAGES flops. Byte capture occurs on the cycle after a synchronised PCLK rising edge (prev=0, cur=1), with synchronised HREF=1.
- Latency: second byte's PCLK edge to pixelValid=1 is SYNC_STAGES+2 CLK_I cycles.
- FSM states:
  - IDLE: wait for synced VSYNC rising edge → WAIT_VS.
  - WAIT_VS: on VSYNC falling edge → ACTIVE. In the same cycle, pulse frameStart and clear col/row/phase and pixelValid.
  - ACTIVE: capture bytes.
    - Phase 0 latches the high byte.
    - Phase 1 forms the pixel.
    - HREF falling edge: row+1, col=0, phase=0. A half pixel is discarded and does not set overflow.
    - Row reaching ROWS → DONE.
    - VSYNC rising edge in ACTIVE (short frame) → WAIT_VS; no frameDone.
  - DONE: pulse frameDone for one cycle → IDLE.
- Pixel formed:
  - If pixelValid=0, or pixelAck=1 in the same cycle: load pixelData/X/Y and set pixelValid=1.
  - Otherwise drop the pixel and set overflow=1. overflow is cleared only by reset.
- pixelAck with pixelValid=1 and no new pixel: pixelValid→0 next cycle. pixelAck while pixelValid=0 is ignored.
- Column saturates at COLS-1; extra pixels on a line are dropped and do not set overflow. Row and column widths are 9 bits, unsigned.
- HREF ignored outside ACTIVE.

Optional Feature:
- Macro CAM_TEST_PATTERN_EN.
- Defined: adds input testMode (1 bit). When testMode=1, the camData byte is ignored, and each formed pixel is an 8-band colour bar selected by pixelX[7:5]:
  - FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Timing still follows camera PCLK/HREF/VSYNC.
- Undefined: no testMode port; logic absent.

Decomposition:
- Package cam_capture_pkg:
  - state enum (IDLE, WAIT_VS, ACTIVE, DONE)
  - default COLS/ROWS constants
  - colour-bar constant array
- Sub-module cam_input_sync: a SYNC_STAGES-deep synchroniser for the 11 camera bits, plus PCLK/HREF/VSYNC edge detectors.

Test Plan:
- Reset mid-line:
  - Stimulus: assert RST_I low during ACTIVE after 3 bytes, then release.
  - Response: all outputs 0, and no pixel appears until the next full VSYNC pulse.
- Basic frame:
  - Stimulus: VSYNC pulse, then 2 lines × 2 pixels with bytes F8,00,07,E0 and pixelAck held high (ROWS=2, COLS=2).
  - Response: frameStart 1 cycle; pixels F800@(0,0), 07E0@(1,0), then line 2 at y=1; frameDone once.
- Backpressure:
  - Stimulus: pixelAck=0, two pixels arrive.
  - Response: first pixel held, second dropped, overflow=1. Then ack: pixelValid→0 and overflow stays 1.
- Simultaneous ack and new pixel:
  - Response: pixelValid stays 1 and pixelData updates in the same cycle, with no overflow.
- Short frame and odd line:
  - Stimulus: HREF falls after 3 bytes, and VSYNC rises mid-frame.
  - Response: third byte discarded and next line starts at col 0 phase 0; frameStart re-fires with no frameDone.
- CAM_TEST_PATTERN_EN, testMode=1, COLS=240:
  - Response: pixelX=0 → FFFF, pixelX=32 → FFE0, pixelX=224 → 0000.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera capture path: FSM states, default frame geometry
// and the colour-bar table used by the optional test pattern.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int DEFAULT_COLS = 240;
    localparam int DEFAULT_ROWS = 320;

    // Index 0 is the leftmost band (white), index 7 the rightmost (black).
    localparam logic [7:0][15:0] COLOUR_BARS = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

endpackage

// File: rtl/cam_input_sync.sv
// Synchronises the 11 camera bits into core_clk and emits registered PCLK/HREF/VSYNC edge strobes.
// Latency SYNC_STAGES+1 cycles to the strobes and aligned data; no backpressure (free-running sampler).
module cam_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       core_clk,
    input  logic       arst_n,
    input  logic       pclk,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] data,
    output logic [7:0] data_dat,
    output logic       href_lvl,
    output logic       pclk_rise,
    output logic       href_fall,
    output logic       vsync_rise,
    output logic       vsync_fall
);

    logic [10:0] sync_r [SYNC_STAGES];
    logic [10:0] sync_last;
    logic [2:0]  prev_r;   // {vsync, href, pclk} from the previous synchronised sample

    assign sync_last = sync_r[SYNC_STAGES-1];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
            prev_r     <= '0;
            data_dat   <= '0;
            href_lvl   <= 1'b0;
            pclk_rise  <= 1'b0;
            href_fall  <= 1'b0;
            vsync_rise <= 1'b0;
            vsync_fall <= 1'b0;
        end else begin
            sync_r[0] <= {vsync, href, pclk, data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
            prev_r     <= sync_last[10:8];
            data_dat   <= sync_last[7:0];
            href_lvl   <= sync_last[9];
            pclk_rise  <=  sync_last[8]  & ~prev_r[0];
            href_fall  <= ~sync_last[9]  &  prev_r[1];
            vsync_rise <=  sync_last[10] & ~prev_r[2];
            vsync_fall <= ~sync_last[10] &  prev_r[2];
        end
    end

endmodule

// File: rtl/cam_pixel_capture.sv
// Captures OV7670 byte pairs into RGB565 pixels; second byte's PCLK edge to pixelValid is SYNC_STAGES+2 cycles.
// Single-slot valid/ack output: a pixel formed while the slot is full is dropped and sets sticky overflow. Option: CAM_TEST_PATTERN_EN.
module cam_pixel_capture
    import cam_capture_pkg::*;
#(
    parameter int COLS        = DEFAULT_COLS,
    parameter int ROWS        = DEFAULT_ROWS,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        camPclk,
    input  logic        camVsync,
    input  logic        camHref,
    input  logic [7:0]  camData,
`ifdef CAM_TEST_PATTERN_EN
    input  logic        testMode,
`endif
    input  logic        pixelAck,
    output logic [15:0] pixelData,
    output logic        pixelValid,
    output logic        frameStart,
    output logic        frameDone,
    output logic [8:0]  pixelX,
    output logic [8:0]  pixelY,
    output logic        overflow
);

    localparam logic [8:0] COL_MAX = 9'(COLS - 1);
    localparam logic [9:0] ROW_END = 10'(ROWS);

    logic [7:0]  data_dat;
    logic        href_lvl, pclk_rise, href_fall, vsync_rise, vsync_fall;
    cap_state_t  state;
    logic [8:0]  col, row;
    logic [9:0]  row_next;
    logic        phase, line_full;
    logic [7:0]  hi_byte;
    logic [15:0] new_pix;

    cam_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .core_clk  (CLK_I),
        .arst_n    (RST_I),
        .pclk      (camPclk),
        .vsync     (camVsync),
        .href      (camHref),
        .data      (camData),
        .data_dat  (data_dat),
        .href_lvl  (href_lvl),
        .pclk_rise (pclk_rise),
        .href_fall (href_fall),
        .vsync_rise(vsync_rise),
        .vsync_fall(vsync_fall)
    );

    assign row_next = {1'b0, row} + 10'd1;

`ifdef CAM_TEST_PATTERN_EN
    assign new_pix = testMode ? COLOUR_BARS[col[7:5]] : {hi_byte, data_dat};
`else
    assign new_pix = {hi_byte, data_dat};
`endif

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            phase      <= 1'b0;
            line_full  <= 1'b0;
            hi_byte    <= '0;
            pixelData  <= '0;
            pixelValid <= 1'b0;
            pixelX     <= '0;
            pixelY     <= '0;
            frameStart <= 1'b0;
            frameDone  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frameStart <= 1'b0;
            frameDone  <= 1'b0;
            if (pixelAck && pixelValid) pixelValid <= 1'b0;

            case (state)
                IDLE: if (vsync_rise) state <= WAIT_VS;
                WAIT_VS: begin
                    if (vsync_fall) begin
                        state      <= ACTIVE;
                        frameStart <= 1'b1;
                        col        <= '0;
                        row        <= '0;
                        phase      <= 1'b0;
                        line_full  <= 1'b0;
                        pixelValid <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vsync_rise) begin
                        state <= WAIT_VS;   // short frame: restart without frameDone
                    end else if (href_fall) begin
                        row       <= row_next[8:0];
                        col       <= '0;
                        phase     <= 1'b0;
                        line_full <= 1'b0;
                        if (row_next == ROW_END) state <= DONE;
                    end else if (pclk_rise && href_lvl) begin
                        if (!phase) begin
                            hi_byte <= data_dat;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            // Pixels beyond the last column are discarded silently.
                            if (!line_full) begin
                                if (!pixelValid || pixelAck) begin
                                    pixelData  <= new_pix;
                                    pixelX     <= col;
                                    pixelY     <= row;
                                    pixelValid <= 1'b1;
                                end else begin
                                    overflow <= 1'b1;
                                end
                                if (col == COL_MAX) line_full <= 1'b1;
                                else                col       <= col + 9'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    frameDone <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed and randomised frames against a queue-based model of the expected pixel stream.
module tb_cam_pixel_capture;

    localparam int SYNC    = 2;
    localparam int ROWS_TB = 2;
`ifdef CAM_TEST_PATTERN_EN
    localparam int COLS_TB = 240;
`else
    localparam int COLS_TB = 2;
`endif

    logic        clk = 1'b0;
    logic        RST_I, camPclk, camVsync, camHref, pixelAck;
    logic [7:0]  camData;
    logic [15:0] pixelData;
    logic        pixelValid, frameStart, frameDone, overflow;
    logic [8:0]  pixelX, pixelY;
`ifdef CAM_TEST_PATTERN_EN
    logic        testMode;
`endif
    bit          tm_on;

    int n_total = 0, n_pass = 0, n_fail = 0;
    int fs_cnt = 0, fd_cnt = 0;
    logic [33:0] got_q[$], exp_q[$];
    logic [7:0]  lb[$];
    logic [15:0] bars_tb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    cam_pixel_capture #(.COLS(COLS_TB), .ROWS(ROWS_TB), .SYNC_STAGES(SYNC)) dut (
        .CLK_I     (clk),
        .RST_I     (RST_I),
        .camPclk   (camPclk),
        .camVsync  (camVsync),
        .camHref   (camHref),
        .camData   (camData),
`ifdef CAM_TEST_PATTERN_EN
        .testMode  (testMode),
`endif
        .pixelAck  (pixelAck),
        .pixelData (pixelData),
        .pixelValid(pixelValid),
        .frameStart(frameStart),
        .frameDone (frameDone),
        .pixelX    (pixelX),
        .pixelY    (pixelY),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Record every handshake-accepted pixel and every strobe cycle.
    always @(negedge clk) begin
        if (pixelValid === 1'b1 && pixelAck === 1'b1) got_q.push_back({pixelData, pixelX, pixelY});
        if (frameStart === 1'b1) fs_cnt++;
        if (frameDone === 1'b1)  fd_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        camData = b;
        ticks(4);
        camPclk = 1'b1;
        ticks(4);
        camPclk = 1'b0;
    endtask

    task automatic vsync_pulse();
        camVsync = 1'b1;
        ticks(8);
        camVsync = 1'b0;
        ticks(8);
    endtask

    task automatic fill_random(input int n);
        lb.delete();
        repeat (n) lb.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [15:0] model_pixel(input logic [7:0] hi, input logic [7:0] lo, input int x);
        if (tm_on) return bars_tb[x / 32];
        return {hi, lo};
    endfunction

    // Sends lb as one line; whole byte pairs within the column budget become expected pixels.
    task automatic send_line(input int row);
        camHref = 1'b1;
        ticks(2);
        foreach (lb[i]) send_byte(lb[i]);
        for (int i = 0; i < lb.size() / 2; i++)
            if (i < COLS_TB) exp_q.push_back({model_pixel(lb[2*i], lb[2*i+1], i), 9'(i), 9'(row)});
        camHref = 1'b0;
        ticks(8);
    endtask

    task automatic check_got(input string tag);
        ticks(4);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"},  pixelData,  16'h0);
        chk({tag, "_valid"}, pixelValid, 1'b0);
        chk({tag, "_fs"},    frameStart, 1'b0);
        chk({tag, "_fd"},    frameDone,  1'b0);
        chk({tag, "_x"},     pixelX,     9'h0);
        chk({tag, "_y"},     pixelY,     9'h0);
        chk({tag, "_ovf"},   overflow,   1'b0);
    endtask

    initial begin
        int fs0, fd0, lat;
        RST_I = 1'b0; camPclk = 1'b0; camVsync = 1'b0; camHref = 1'b0;
        camData = 8'h00; pixelAck = 1'b0; tm_on = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
        testMode = 1'b0;
`endif
        ticks(3);
        check_reset_outputs("rst");
        RST_I = 1'b1;
        ticks(4);

        // Basic two-line frame with the consumer always ready.
        pixelAck = 1'b1;
        fs0 = fs_cnt; fd0 = fd_cnt;
        vsync_pulse();
        chk("basic_fs", fs_cnt - fs0, 1);
        lb = '{8'hF8, 8'h00, 8'h07, 8'hE0};
        send_line(0);
        lb = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        send_line(1);
        ticks(4);
        chk("basic_fd", fd_cnt - fd0, 1);
        check_got("basic");

        // Line activity outside a frame must produce nothing.
        lb = '{8'h11, 8'h22, 8'h33, 8'h44};
        camHref = 1'b1; ticks(2);
        foreach (lb[i]) send_byte(lb[i]);
        camHref = 1'b0; ticks(8);
        check_got("idle_href");

        // Asynchronous reset part-way through a line.
        vsync_pulse();
        camHref = 1'b1; ticks(2);
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h33);
        exp_q.push_back({16'hA55A, 9'd0, 9'd0});
        RST_I = 1'b0;
        #2;
        check_reset_outputs("midrst");
        ticks(3);
        RST_I = 1'b1;
        ticks(2);
        send_byte(8'h77); send_byte(8'h88);
        camHref = 1'b0; ticks(8);
        chk("midrst_novalid", pixelValid, 1'b0);
        check_got("midrst");

        // Latency, hold without ack, then ack coinciding with the next pixel.
        fd0 = fd_cnt;
        vsync_pulse();
        pixelAck = 1'b0;
        camHref = 1'b1; ticks(2);
        send_byte(8'hC3);
        camData = 8'h3C; ticks(4);
        camPclk = 1'b1;
        lat = 0;
        while (pixelValid !== 1'b1 && lat < 12) begin tick(); lat++; end
        chk("latency", lat, SYNC + 2);
        camPclk = 1'b0;
        chk("hold_data", pixelData, 16'hC33C);
        exp_q.push_back({16'hC33C, 9'd0, 9'd0});
        send_byte(8'h81);
        camData = 8'h18; ticks(4);
        camPclk = 1'b1;
        ticks(3);
        pixelAck = 1'b1;
        tick();
        pixelAck = 1'b0;
        chk("simul_valid", pixelValid, 1'b1);
        chk("simul_data",  pixelData,  16'h8118);
        chk("simul_x",     pixelX,     9'd1);
        chk("simul_ovf",   overflow,   1'b0);
        exp_q.push_back({16'h8118, 9'd1, 9'd0});
        ticks(3);
        camPclk = 1'b0;
        pixelAck = 1'b1;
        ticks(2);
        // Two further pixels on the same line: beyond the last column when COLS is 2.
        fill_random(4);
        foreach (lb[i]) send_byte(lb[i]);
        for (int i = 0; i < 2; i++)
            if (i + 2 < COLS_TB) exp_q.push_back({lb[2*i], lb[2*i+1], 9'(i + 2), 9'd0});
        camHref = 1'b0; ticks(8);
        chk("extra_ovf", overflow, 1'b0);
        chk("extra_valid", pixelValid, 1'b0);
        fill_random(4);
        send_line(1);
        chk("f2_fd", fd_cnt - fd0, 1);
        check_got("f2");

        // Odd-length line: the trailing half pixel is discarded.
        vsync_pulse();
        lb = '{8'h11, 8'h22, 8'h33};
        send_line(0);
        lb = '{8'h44, 8'h55, 8'h66, 8'h77};
        send_line(1);
        check_got("oddline");

        // VSYNC rising mid-frame restarts the frame without frameDone.
        fs0 = fs_cnt; fd0 = fd_cnt;
        vsync_pulse();
        fill_random(4);
        send_line(0);
        vsync_pulse();
        chk("short_fs", fs_cnt - fs0, 2);
        chk("short_fd", fd_cnt - fd0, 0);
        fill_random(4);
        send_line(0);
        fill_random(2);
        send_line(1);
        chk("short_fd_after", fd_cnt - fd0, 1);
        check_got("short");

        // Randomised frames with varying line lengths.
        fd0 = fd_cnt;
        for (int f = 0; f < 5; f++) begin
            vsync_pulse();
            for (int r = 0; r < ROWS_TB; r++) begin
                fill_random($urandom_range(0, (COLS_TB < 8) ? 2 * COLS_TB + 3 : 9));
                send_line(r);
            end
        end
        chk("rand_fd", fd_cnt - fd0, 5);
        chk("rand_ovf", overflow, 1'b0);
        check_got("rand");

`ifdef CAM_TEST_PATTERN_EN
        tm_on = 1'b1;
        testMode = 1'b1;
        vsync_pulse();
        fill_random(2 * 225 + 1);
        send_line(0);
        lb.delete();
        send_line(1);
        check_got("tpat");
        testMode = 1'b0;
        tm_on = 1'b0;
`endif

        // Backpressure: second pixel dropped while the first is still held.
        vsync_pulse();
        pixelAck = 1'b0;
        camHref = 1'b1; ticks(2);
        send_byte(8'hE1); send_byte(8'h1E);
        ticks(4);
        chk("bp_valid", pixelValid, 1'b1);
        chk("bp_data",  pixelData,  16'hE11E);
        send_byte(8'hD2); send_byte(8'h2D);
        ticks(6);
        chk("bp_hold", pixelData, 16'hE11E);
        chk("bp_x",    pixelX,    9'd0);
        chk("bp_ovf",  overflow,  1'b1);
        pixelAck = 1'b1;
        tick();
        pixelAck = 1'b0;
        tick();
        chk("bp_ack_valid", pixelValid, 1'b0);
        chk("bp_ack_ovf",   overflow,   1'b1);
        exp_q.push_back({16'hE11E, 9'd0, 9'd0});
        camHref = 1'b0; ticks(8);
        lb.delete();
        send_line(1);
        check_got("bp");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
